// File: rtl/prog_link_pkg.sv
// Shared types and constants for the 8-bit
// instruction fetch link.
package prog_link_pkg;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    SETUP,
    ACK
  } srv_state_t;

  localparam int LINK_ADDR_W          = 8;
  localparam int LINK_DATA_W          = 8;
  localparam int DEFAULT_SETUP_CYCLES = 4;

endpackage

// File: rtl/bit_synchronizer.sv
// Multi-flop synchronizer for a single
// asynchronous control bit.
module bit_synchronizer #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/program_rom_server.sv
// Program-memory responder: serves byte fetches
// over a four-phase req/ack link, host-writable.
module program_rom_server
  import prog_link_pkg::*;
#(
  parameter int DEPTH        = 256,
  parameter int SETUP_CYCLES = DEFAULT_SETUP_CYCLES,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_in,
  input  logic [LINK_ADDR_W-1:0] addr_in,
  output logic [LINK_DATA_W-1:0] data_out,
  output logic                   ack_out,
  input  logic                   prog_we,
  input  logic [LINK_ADDR_W-1:0] prog_addr,
  input  logic [LINK_DATA_W-1:0] prog_data,
  output logic                   busy,
  output logic [15:0]            xfer_count,
  output logic                   abort_flag
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] SC = 4'(SETUP_CYCLES);

  srv_state_t state_q, state_d;
  logic [LINK_ADDR_W-1:0] addr_q, addr_d;
  logic [LINK_DATA_W-1:0] data_q, data_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [15:0]            count_q, count_d;
  logic                   ack_q, ack_d;
  logic                   abort_q, abort_d;
  logic                   armed_q, armed_d;
  logic                   req_s;

  logic [LINK_DATA_W-1:0] rom [DEPTH];
  logic [LINK_DATA_W-1:0] rom_q;

  bit_synchronizer #(
    .STAGES(SYNC_STAGES)
  ) u_req_sync (
    .clk  (clk),
    .rst_n(rst),
    .d_i  (req_in),
    .q_o  (req_s)
  );

  // Read-first: a write landing on the READ edge
  // leaves rom_q with the old byte.
  always_ff @(posedge clk) begin
    if (prog_we && (int'(prog_addr) < DEPTH)) begin
      rom[prog_addr[AW-1:0]] <= prog_data;
    end
    if (state_q == READ) begin
      rom_q <= (int'(addr_q) < DEPTH) ?
               rom[addr_q[AW-1:0]] : '0;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    count_d = count_q;
    ack_d   = ack_q;
    abort_d = abort_q;
    armed_d = armed_q;
    if (!req_s) armed_d = 1'b1;
    unique case (state_q)
      IDLE: begin
        if (req_s && armed_q) begin
          addr_d  = addr_in;
          armed_d = 1'b0;
          state_d = READ;
        end
      end
      READ: begin
        if (!req_s) begin
          abort_d = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d   = '0;
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (!req_s) begin
          abort_d = 1'b1;
          state_d = IDLE;
        end else begin
          if (cnt_q == '0) data_d = rom_q;
          if (cnt_q == SC) begin
            ack_d   = 1'b1;
            state_d = ACK;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      ACK: begin
        if (!req_s) begin
          ack_d   = 1'b0;
          count_d = count_q + 16'd1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      count_q <= '0;
      ack_q   <= 1'b0;
      abort_q <= 1'b0;
      armed_q <= 1'b1;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      count_q <= count_d;
      ack_q   <= ack_d;
      abort_q <= abort_d;
      armed_q <= armed_d;
    end
  end

  assign data_out   = data_q;
  assign ack_out    = ack_q;
  assign busy       = (state_q != IDLE);
  assign xfer_count = count_q;
  assign abort_flag = abort_q;

endmodule

// File: tb/tb_program_rom_server.sv
// Directed self-checking bench for
// program_rom_server.
module tb_program_rom_server;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req_in = 1'b0;
  logic [7:0] addr_in = '0;
  logic       prog_we = 1'b0;
  logic [7:0] prog_addr = '0;
  logic [7:0] prog_data = '0;
  logic [7:0] data_out;
  logic       ack_out;
  logic       busy;
  logic [15:0] xfer_count;
  logic       abort_flag;

  logic       req2 = 1'b0;
  logic [7:0] addr2 = '0;
  logic [7:0] data2;
  logic       ack2;
  logic       busy2;
  logic [15:0] count2;
  logic       abort2;

  int errors = 0;
  int checks = 0;
  int exp_cnt = 0;

  program_rom_server dut (
    .clk(clk), .rst(rst),
    .req_in(req_in), .addr_in(addr_in),
    .data_out(data_out), .ack_out(ack_out),
    .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .busy(busy),
    .xfer_count(xfer_count), .abort_flag(abort_flag)
  );

  program_rom_server #(.DEPTH(128)) dut2 (
    .clk(clk), .rst(rst),
    .req_in(req2), .addr_in(addr2),
    .data_out(data2), .ack_out(ack2),
    .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .busy(busy2),
    .xfer_count(count2), .abort_flag(abort2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] a,
                    input logic [7:0] d);
    prog_we = 1'b1;
    prog_addr = a;
    prog_data = d;
    step();
    prog_we = 1'b0;
  endtask

  task automatic fetch(input logic [7:0] a,
                       input logic [7:0] exp,
                       input int hold,
                       input bit wr_rd,
                       input logic [7:0] wd);
    bit bad;
    addr_in = a;
    req_in = 1'b1;
    step();              // T0
    step(2);             // T0+2
    chk("busy_in_read", busy, 1);
    if (wr_rd) begin
      prog_we = 1'b1;
      prog_addr = a;
      prog_data = wd;
    end
    step();              // T0+3
    prog_we = 1'b0;
    step();              // T0+4
    chk("data_t4", data_out, exp);
    step(3);             // T0+7
    chk("ack_low_t7", ack_out, 0);
    step();              // T0+8
    chk("ack_high_t8", ack_out, 1);
    bad = 1'b0;
    for (int i = 0; i < hold; i++) begin
      step();
      if (ack_out !== 1'b1 || xfer_count !== 16'(exp_cnt))
        bad = 1'b1;
    end
    if (hold > 0) chk("hold_single", bad, 0);
    req_in = 1'b0;
    step(2);
    chk("ack_held_r1", ack_out, 1);
    step();
    chk("ack_fall_r2", ack_out, 0);
    exp_cnt++;
    chk("xfer_count", xfer_count, exp_cnt);
  endtask

  typedef struct {
    logic [7:0] addr;
    bit         do_wr;
    logic [7:0] wdata;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl[6];

  initial begin
    bit seen;
    tbl[0] = '{8'h11, 1'b1, 8'h5A, 8'h5A};
    tbl[1] = '{8'h00, 1'b1, 8'hFF, 8'hFF};
    tbl[2] = '{8'hFF, 1'b1, 8'h81, 8'h81};
    tbl[3] = '{8'h10, 1'b0, 8'h00, 8'hA5};
    tbl[4] = '{8'h7F, 1'b1, 8'h01, 8'h01};
    tbl[5] = '{8'h11, 1'b0, 8'h00, 8'h5A};

    #12;
    chk("rst_data", data_out, 0);
    chk("rst_ack", ack_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_count", xfer_count, 0);
    chk("rst_abort", abort_flag, 0);
    chk("rst_data2", data2, 0);
    @(negedge clk);
    rst = 1'b1;
    step(2);

    wr(8'h10, 8'hA5);
    fetch(8'h10, 8'hA5, 40, 1'b0, 8'h00);
    chk("count_after_hold", xfer_count, 1);

    foreach (tbl[i]) begin
      if (tbl[i].do_wr) wr(tbl[i].addr, tbl[i].wdata);
      fetch(tbl[i].addr, tbl[i].exp, 0, 1'b0, 8'h00);
    end
    chk("no_abort_yet", abort_flag, 0);

    wr(8'h20, 8'h00);
    fetch(8'h20, 8'h00, 0, 1'b1, 8'h3C);
    fetch(8'h20, 8'h3C, 0, 1'b0, 8'h00);

    // Withdraw the request in SETUP.
    addr_in = 8'h10;
    req_in = 1'b1;
    step();
    step(4);
    req_in = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (ack_out !== 1'b0) seen = 1'b1;
    end
    chk("abort_no_ack", seen, 0);
    chk("abort_flag", abort_flag, 1);
    chk("abort_count", xfer_count, exp_cnt);
    chk("abort_idle", busy, 0);

    // DEPTH=128 instance: in-range works,
    // out-of-range reads zero and is not aliased.
    wr(8'h90, 8'h5A);
    addr2 = 8'h10;
    req2 = 1'b1;
    step(5);
    chk("d128_in_range", data2, 8'hA5);
    req2 = 1'b0;
    step(10);
    addr2 = 8'h90;
    req2 = 1'b1;
    step(5);
    chk("d128_busy", busy2, 1);
    chk("d128_out_range", data2, 8'h00);
    req2 = 1'b0;
    step(10);

    // Reset while acknowledging.
    addr_in = 8'h10;
    req_in = 1'b1;
    step(9);
    chk("pre_rst_ack", ack_out, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_ack", ack_out, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_data", data_out, 0);
    chk("mid_rst_count", xfer_count, 0);
    chk("mid_rst_abort", abort_flag, 0);
    req_in = 1'b0;
    step(2);
    @(negedge clk);
    rst = 1'b1;
    step(2);
    exp_cnt = 0;
    fetch(8'h10, 8'hA5, 0, 1'b0, 8'h00);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule

// File: doc/program_rom_server.md
# program_rom_server

Program-memory responder on the far side of the processor board's 8-bit instruction fetch link. It holds the byte-addressed program image and answers each fetch with a four-phase req/ack handshake. The requester's `transmit_signal` and `instruction_address_output` drive this block's `req_in` and `addr_in`. This block's `data_out` and `ack_out` return to the requester's `instruction_input` and `receive_signal`. It runs on its own board clock, asynchronous to the requester, and adds a host-side programming port plus link statistics.

## Interface
Parameters:
- `DEPTH`, 256: ROM bytes; address width is 8, so `DEPTH` ≤ 256.
- `SETUP_CYCLES`, 4: cycles `data_out` is held stable before `ack_out` rises (range 1..15).
- `SYNC_STAGES`, 2: flops in the `req_in` synchronizer (≥ 2).

Ports:
- `clk`  input  1  board clock.
- `rst`  input  1  asynchronous, active-low reset.
- `req_in`  input  1  fetch request from the requester; asynchronous to `clk`.
- `addr_in`  input  8  byte address; stable whenever `req_in` is high.
- `data_out`  output  8  ROM byte for the current fetch.
- `ack_out`  output  1  fetch acknowledge.
- `prog_we`  input  1  host write strobe.
- `prog_addr`  input  8  host write address.
- `prog_data`  input  8  host write data.
- `busy`  output  1  high in every state except `IDLE`.
- `xfer_count`  output  16  completed handshakes; wraps.
- `abort_flag`  output  1  sticky; a request was withdrawn before ack. Cleared only by reset.

## Operation
- FSM states:
  - `IDLE`: when `req_s` = 1 and `req_armed` = 1, capture `addr_in` into `addr_q` and go to `READ`.
  - `READ`: synchronous ROM read of `addr_q`, then go to `SETUP`.
  - `SETUP`: `data_out` ← ROM data on entry. Count `SETUP_CYCLES`, then go to `ACK`.
  - `ACK`: `ack_out` = 1. When `req_s` = 0, drop ack, increment `xfer_count`, go to `IDLE`.
- `req_armed` is set when `req_s` is seen low and cleared on capture. A request held high after the handshake is never serviced twice.
- Addresses ≥ `DEPTH` return 0x00.
- Abort: if `req_s` falls in `READ` or `SETUP`, set `abort_flag` and go to `IDLE`. No ack is sent and the count is unchanged.
- Programming:
  - `prog_we` writes `prog_data` to `prog_addr` on any cycle, in any state.
  - The ROM is read-first. A same-address write in the `READ` cycle returns the old byte; the next fetch sees the new byte.
- Reset mid-transfer: all outputs return to reset values immediately and ROM contents are kept. The requester sees ack fall and must restart its fetch.
- Reset values: `data_out` = 0x00, `ack_out` = 0, `busy` = 0, `xfer_count` = 0, `abort_flag` = 0, state `IDLE`, `req_armed` = 1.

## Timing
- Let T0 be the first edge that samples `req_in` high.
  - `req_s` is high after `SYNC_STAGES` edges (T0+1 with the default of 2).
  - `IDLE` → `READ` at T0+2.
  - `data_out` is valid at T0+4.
  - `ack_out` rises at T0+4+`SETUP_CYCLES` (T0+8 by default).
- `ack_out` and `data_out` are registered outputs with no combinational path from any input.
- Release: `ack_out` falls 1 cycle after `req_s` is seen low, i.e. `SYNC_STAGES`+1 edges after `req_in` falls. `xfer_count` updates on that same edge.
- `data_out` holds its value from `SETUP` until the next `SETUP` entry.
- Minimum back-to-back fetch period: 2×`SYNC_STAGES` + `SETUP_CYCLES` + 4 cycles.

## Structure
- Shared package `prog_link_pkg`:
  - `srv_state_t` enum (`IDLE`, `READ`, `SETUP`, `ACK`).
  - `LINK_ADDR_W` = 8, `LINK_DATA_W` = 8, `DEFAULT_SETUP_CYCLES` = 4.
- Sub-module `bit_synchronizer`: a `SYNC_STAGES`-deep flop chain with asynchronous active-low reset to 0. It is used for `req_in`.
- ROM: inferred as a single-port-write / single-port-read array.

## Test plan
- Reset, write 0xA5 to address 0x10, drive `addr_in` = 0x10 and raise `req_in` → `data_out` = 0xA5 at T0+4, `ack_out` = 1 at T0+8. Drop req → ack falls 3 edges later and `xfer_count` = 1.
- Hold `req_in` high for 40 cycles after ack → exactly one transfer, `xfer_count` stays 1. Drop req, then re-raise with address 0x11 → second transfer, count = 2.
- Raise req, drop it at T0+5 (in `SETUP`) → `ack_out` never rises, `abort_flag` = 1, `xfer_count` unchanged.
- With `DEPTH` = 128, fetch address 0x90 → `data_out` = 0x00.
- Write 0x3C to 0x20 in the `READ` cycle of a fetch of 0x20 (old byte 0x00) → that fetch returns 0x00, the next fetch returns 0x3C.
- Assert `rst` low while in `ACK` → `ack_out` = 0 and `busy` = 0 on the same cycle. ROM byte 0x10 is still 0xA5 after reset.
